// File: rtl/arith_muldiv.sv
// Multi-cycle multiply/divide unit for MULT/MULTU/DIV/DIVU.
// One bit per cycle: shift-add multiply and restoring divide, with a sign fix-up step.
module arith_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             z,
   output logic             n,
   output logic             dz
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dzero_q, dzero_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             z_q, z_d, n_q, n_d, dz_q, dz_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Magnitudes of signed operands; MIN maps to 2^(WIDTH-1) held unsigned.
   assign a_neg = op[0] & A[WIDTH-1];
   assign b_neg = op[0] & B[WIDTH-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};

   // With a zero divisor the restoring loop leaves |A| as remainder, so the
   // dividend-sign correction below reproduces the original A in hi.
   assign prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign quo_fix  = dzero_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
   assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dzero_d   = dzero_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      z_d       = z_q;
      n_d       = n_q;
      dz_d      = dz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               cnt_d     = CW'(WIDTH);
               is_div_d  = op[1];
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dzero_d   = op[1] & (B == '0);
               acc_hi_d  = '0;
               acc_lo_d  = op[1] ? a_mag : b_mag;
               mcand_d   = op[1] ? b_mag : a_mag;
            end
         end
         StRun: begin
            if (cnt_q == '0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (is_div_q) begin
                  acc_hi_d = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
               end else begin
                  acc_hi_d = mul_sum[WIDTH:1];
                  acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
               end
            end
         end
         StFix: begin
            state_d = StDone;
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
               z_d  = (quo_fix == '0);
               n_d  = quo_fix[WIDTH-1];
               dz_d = dzero_q;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
               z_d  = (prod_fix == '0);
               n_d  = prod_fix[2*WIDTH-1];
               dz_d = 1'b0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dzero_q   <= 1'b0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dzero_q   <= dzero_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         z_q       <= z_d;
         n_q       <= n_d;
         dz_q      <= dz_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign z    = z_q;
   assign n    = n_q;
   assign dz   = dz_q;

endmodule

// File: doc/arith_muldiv.md
Name: arith_muldiv

Overview:
Multi-cycle, width-parametrised multiply/divide unit for the MIPS datapath. It sits beside the single-cycle add/sub unit and serves MULT/MULTU/DIV/DIVU. Results go to HI/LO, with z/n status flags and a divide-by-zero flag. It computes one bit per cycle (shift-add multiply, restoring divide) and uses a start/busy/done handshake with the controller.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits; must be >= 4.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
A  input  WIDTH  multiplicand / dividend; captured on the accepted start edge
B  input  WIDTH  multiplier / divisor; captured on the accepted start edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; hi/lo/flags valid from this cycle
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
z  output  1  result zero: {hi,lo}==0 for multiply, lo==0 for divide
n  output  1  hi[WIDTH-1] for multiply, lo[WIDTH-1] for divide
dz  output  1  divide by zero on the last divide op; 0 for multiply

Behaviour:
- Reset (async, any state, including mid-operation):
  - state goes to IDLE.
  - busy, done, z, n, dz = 0; hi, lo = 0.
  - The pending operation is discarded and no done is issued.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with start=1, capture op, A, B and go to RUN.
  - Signed ops (op[0]=1) capture operand magnitudes and record the result sign(s).
  - A signed-op operand of value MIN (100..0) has magnitude 2^(WIDTH-1), held unsigned.
  - The iteration counter loads WIDTH.
- RUN:
  - One iteration per edge; the counter decrements.
  - Multiply: conditional add of the multiplicand, then shift; 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract; quotient bit = 1 when the trial subtraction is non-negative.
  - After WIDTH iterations, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Signed multiply: negate the 2*WIDTH product when the operand signs differ.
  - Signed divide: negate the quotient when the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - Register hi, lo, z, n, dz. Go to DONE.
- DONE: done=1 for this single cycle, then return to IDLE.
- busy = 1 in RUN, FIX and DONE; 0 in IDLE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+WIDTH+2. Back-to-back start in the cycle after done is accepted.
- start while busy is ignored; captured operands and the result are unaffected.
- A and B may change freely after the accepted start edge.
- hi/lo/flags hold their value from done until the FIX of the next operation. Between start and the next done they are don't-care for consumers, but must not glitch to X.
- Divide by zero (B==0, DIVU or DIV):
  - Full latency still applies.
  - dz=1, lo = all ones, hi = A (original captured value, not the magnitude).
  - z and n are computed from lo.
- Signed overflow DIV MIN / -1: lo = MIN, hi = 0, dz=0; no trap.
- Multiply never overflows (full 2*WIDTH result); dz=0.
- All arithmetic is modulo 2^WIDTH per half; there is no internal width narrowing.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> done 34 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB, z=0, n=1, dz=0.
- MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, n=1; then MULTU A=0, B=0x1234 -> hi=lo=0, z=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=7, B=2 -> lo=3, hi=1, z=0, n=0.
- Boundaries:
  - DIVU A=0x64, B=0 -> dz=1, lo=0xFFFFFFFF, hi=0x64, n=1.
  - DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Start at edge k, then start pulsed again mid-RUN with A=B=5 (MULTU) -> single done pulse at the original latency with the first result; busy continuously high until done.
- Assert reset mid-RUN, then release -> busy/done/hi/lo/flags = 0 immediately (async); no done pulse. A new MULTU 6*7 then gives lo=42, hi=0. Repeat with WIDTH=8: MULT 0x80*0x80 gives hi=0x40, lo=0x00, done at edge k+10.
